// File: rtl/fifo_pop_packer.sv
// fifo_pop_packer: pop-side consumer for the dual-clock FIFO.
// Pops width-bit words, packs ratio of them into one wide word and presents it
// on a valid/ready stream. A flush emits a zero-padded partial word tagged last.

// Lane register: one captured FIFO word, cleared whenever a packed word leaves.
module fifo_pop_packer_lane #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);
  // Capture on write, zero on reset/clear so unfilled lanes read as padding
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (we)    q <= d;
  end
endmodule

module fifo_pop_packer #(
  parameter int width = 8,
  parameter int ratio = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pop_empty,
  input  logic                       pop_error,
  input  logic [width-1:0]           data_in,
  output logic                       pop_req_n,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [width*ratio-1:0]     out_data,
  output logic [$clog2(ratio+1)-1:0] out_count,
  output logic                       out_last,
  output logic                       flush_done,
  output logic                       busy,
  output logic                       err_sticky
);
  localparam int CNTW = (ratio > 1) ? $clog2(ratio) : 1;
  localparam int CW   = $clog2(ratio+1);
  localparam logic [CNTW-1:0] LAST     = CNTW'(ratio-1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(ratio);

  typedef enum logic {ACC, FLUSH} state_t;

  state_t                        state, state_nxt;
  logic [CNTW-1:0]               cnt;
  logic [ratio-2:0][width-1:0]   lane_q;
  logic                          out_free, can_pop, full_pop, part_emit, flush_end;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ACC;
    else     state <= state_nxt;
  end

  // Next state: flush only sampled in ACC; FLUSH exits once it can finish
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (flush)     state_nxt = FLUSH;
      FLUSH:   if (flush_end) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // Control decode; final lane only pops when the output slot frees this edge
  always_comb begin
    out_free  = !out_valid || out_ready;
    can_pop   = (state == ACC) && !pop_empty && !rst && ((cnt != LAST) || out_free);
    full_pop  = can_pop && (cnt == LAST);
    part_emit = (state == FLUSH) && (cnt != '0) && out_free;
    flush_end = (state == FLUSH) && ((cnt == '0) || out_free);
  end

  assign pop_req_n = !can_pop;
  assign busy      = (state == FLUSH) || (cnt != '0) || out_valid;

  // Lanes 0..ratio-2 are registered; the last word goes straight to the output
  for (genvar i = 0; i < ratio-1; i++) begin : g_lane
    fifo_pop_packer_lane #(.width(width)) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (full_pop || part_emit),
      .we  (can_pop && (cnt == CNTW'(i))),
      .d   (data_in),
      .q   (lane_q[i])
    );
  end

  // Lane counter: advances per pop, wraps on completion, clears on partial emit
  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (full_pop)        cnt <= '0;
    else if (can_pop)         cnt <= cnt + CNTW'(1);
    else if (part_emit)       cnt <= '0;
  end

  // Output register: load full or partial word, else drop valid on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
    end else if (full_pop) begin
      out_valid <= 1'b1;
      out_data  <= {data_in, lane_q};
      out_count <= FULL_CNT;
      out_last  <= 1'b0;
    end else if (part_emit) begin
      out_valid <= 1'b1;
      out_data  <= {{width{1'b0}}, lane_q};
      out_count <= CW'(cnt);
      out_last  <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Flush completion pulse and sticky FIFO error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_done <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      flush_done <= flush_end;
      if (pop_error) err_sticky <= 1'b1;
    end
  end
endmodule
